mdio_responder: RTL and testbench

Synthesizable IEEE 802.3 Clause 22 MDIO management responder (PHY side), the target end of the MDC/MDIO link driven by each `eN_mdc`/`eN_mdio` port of `top`. It oversamples MDC/MDIO in the system clock domain, decodes frames addressed to its PHY address, serves reads from and commits writes to an internal 32x16 register file, and drives MDIO through an output/enable pair. The bench uses it as a PHY model, and the FPGA can instantiate it for loopback self-test.

---
 rtl/mdio_responder.sv | 205 ++++++++++++++++++++
 tb/tb_mdio_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_responder.sv
// Clause 22 MDIO responder (PHY side): MDC/MDIO oversampled in the clk domain,
// frames addressed to PHY_ADDR read from / write to a 32x16 register file.
//
// state | meaning
// IDLE  | counting preamble ones
// ST    | second start bit (must be 1)
// OP    | two opcode bits
// PHYAD | five PHY address bits
// REGAD | five register address bits, then address decision
// TA    | turnaround (read: latch + drive 0, write: expect 1,0)
// RDATA | drive 16 data bits on mdc falls, then release
// WDATA | shift 16 data bits, commit on the last rise
// SKIP  | let the rest of a foreign/invalid frame pass

module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter bit          BCAST_EN = 1'b0,
  parameter int          PRE_LEN  = 32,
  parameter logic [15:0] PHY_ID1  = 16'h0022,
  parameter logic [15:0] PHY_ID2  = 16'h1622
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic        wr_strb,
  output logic [4:0]  wr_reg,
  output logic [15:0] wr_data,
  output logic        rd_strb,
  output logic [4:0]  rd_reg
);

  localparam int            PW      = $clog2(PRE_LEN + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRE_LEN);

  typedef enum logic [3:0] {IDLE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA, SKIP} state_t;

  state_t        state;
  logic [2:0]    mdc_sync;
  logic [1:0]    mdio_sync;
  logic [PW-1:0] pre_cnt;
  logic [4:0]    bit_cnt;
  logic [4:0]    phyad;
  logic [4:0]    regad;
  logic          is_rd;
  logic [15:0]   data_sr;
  logic [15:0]   regs [32];

  logic        mdc_rise;
  logic        mdc_fall;
  logic        mdio_bit;
  logic [15:0] wdata_nx;
  logic        addr_ok;

  function automatic logic [15:0] reset_val(input logic [4:0] idx);
    case (idx)
      5'd0:    return 16'h1140;
      5'd1:    return 16'h796D;
      5'd2:    return PHY_ID1;
      5'd3:    return PHY_ID2;
      default: return 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mdc_sync  <= '0;
      mdio_sync <= '1;
    end else begin
      mdc_sync  <= {mdc_sync[1:0], mdc_i};
      mdio_sync <= {mdio_sync[0], mdio_i};
    end
  end

  assign mdc_rise = mdc_sync[1] & ~mdc_sync[2];
  assign mdc_fall = ~mdc_sync[1] & mdc_sync[2];
  assign mdio_bit = mdio_sync[1];
  assign wdata_nx = {data_sr[14:0], mdio_bit};
  // Broadcast address 0 is only honoured for writes.
  assign addr_ok  = is_rd ? (phyad == PHY_ADDR && phyad != 5'd0)
                          : (phyad == PHY_ADDR || (BCAST_EN && phyad == 5'd0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pre_cnt <= '0;
      bit_cnt <= '0;
      phyad   <= '0;
      regad   <= '0;
      is_rd   <= 1'b0;
      data_sr <= '0;
      mdio_o  <= 1'b1;
      mdio_oe <= 1'b0;
      wr_strb <= 1'b0;
      wr_reg  <= '0;
      wr_data <= '0;
      rd_strb <= 1'b0;
      rd_reg  <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= reset_val(5'(i));
    end else begin
      wr_strb <= 1'b0;
      rd_strb <= 1'b0;
      case (state)
        IDLE: if (mdc_rise) begin
          if (mdio_bit) begin
            if (pre_cnt != PRE_MAX) pre_cnt <= pre_cnt + PW'(1);
          end else begin
            if (pre_cnt == PRE_MAX) state <= ST;
            pre_cnt <= '0;
          end
        end
        ST: if (mdc_rise) begin
          state   <= mdio_bit ? OP : IDLE;
          bit_cnt <= 5'd1;
        end
        OP: if (mdc_rise) begin
          if (bit_cnt != 5'd0) begin
            is_rd   <= mdio_bit;
            bit_cnt <= 5'd0;
          end else if (is_rd != mdio_bit) begin
            state   <= PHYAD;
            bit_cnt <= 5'd4;
          end else begin
            state   <= SKIP;
            bit_cnt <= 5'd27;
          end
        end
        PHYAD: if (mdc_rise) begin
          phyad <= {phyad[3:0], mdio_bit};
          if (bit_cnt == 5'd0) begin
            state   <= REGAD;
            bit_cnt <= 5'd4;
          end else bit_cnt <= bit_cnt - 5'd1;
        end
        REGAD: if (mdc_rise) begin
          regad <= {regad[3:0], mdio_bit};
          if (bit_cnt == 5'd0) begin
            state   <= addr_ok ? TA : SKIP;
            bit_cnt <= addr_ok ? 5'd1 : 5'd17;
          end else bit_cnt <= bit_cnt - 5'd1;
        end
        TA: if (is_rd) begin
          if (mdc_rise && bit_cnt != 5'd0) begin
            rd_strb <= 1'b1;
            rd_reg  <= regad;
            data_sr <= regs[regad];
            bit_cnt <= 5'd0;
          end else if (mdc_fall && bit_cnt == 5'd0) begin
            mdio_oe <= 1'b1;
            mdio_o  <= 1'b0;
            state   <= RDATA;
            bit_cnt <= 5'd16;
          end
        end else if (mdc_rise) begin
          if (bit_cnt != 5'd0) begin
            if (mdio_bit) bit_cnt <= 5'd0;
            else begin
              state   <= SKIP;
              bit_cnt <= 5'd16;
            end
          end else begin
            state   <= mdio_bit ? SKIP : WDATA;
            bit_cnt <= 5'd15;
          end
        end
        RDATA: if (mdc_fall) begin
          if (bit_cnt == 5'd0) begin
            mdio_oe <= 1'b0;
            mdio_o  <= 1'b1;
            state   <= IDLE;
          end else begin
            mdio_o  <= data_sr[15];
            data_sr <= {data_sr[14:0], 1'b0};
            bit_cnt <= bit_cnt - 5'd1;
          end
        end
        WDATA: if (mdc_rise) begin
          data_sr <= wdata_nx;
          if (bit_cnt == 5'd0) begin
            state <= IDLE;
            if (!(regad inside {[5'd1:5'd3]})) begin
              wr_strb <= 1'b1;
              wr_reg  <= regad;
              wr_data <= wdata_nx;
              // Soft reset bit self-clears by reloading the whole file.
              if (regad == 5'd0 && wdata_nx[15]) begin
                for (int i = 0; i < 32; i++) regs[i] <= reset_val(5'(i));
              end else begin
                regs[regad] <= wdata_nx;
              end
            end
          end else bit_cnt <= bit_cnt - 5'd1;
        end
        SKIP: if (mdc_rise) begin
          if (bit_cnt == 5'd0) state <= IDLE;
          else bit_cnt <= bit_cnt - 5'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: a station model drives MDC/MDIO frames while a
// scoreboard compares strobes and read data against a register-map model.

module tb_mdio_responder;

  localparam logic [4:0] PHY_ADDR = 5'd1;
  localparam bit         BCAST_EN = 1'b0;
  localparam int         PRE_LEN  = 32;
  localparam logic [1:0] OP_RD    = 2'b10;
  localparam logic [1:0] OP_WR    = 2'b01;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mdc = 1'b0;
  logic        sta_drv = 1'b1;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oe;
  logic        wr_strb;
  logic [4:0]  wr_reg;
  logic [15:0] wr_data;
  logic        rd_strb;
  logic [4:0]  rd_reg;

  int checks = 0;
  int failures = 0;

  logic [4:0]  exp_rd[$];
  logic [20:0] exp_wr[$];
  logic [16:0] exp_rdata[$];
  logic [15:0] model_regs[32];
  int          abort_req = 0;
  int          abort_ack = 0;

  logic [16:0] cap = '0;
  int          ncap = 0;
  logic        mdc_prev = 1'b0;
  logic        prev_oe = 1'b0;

  always #5 clk = ~clk;

  // Open-drain style bus: the PHY wins while it drives, otherwise the station/pull-up.
  assign mdio_i = (mdio_oe === 1'b1) ? mdio_o : sta_drv;

  mdio_responder #(
    .PHY_ADDR(PHY_ADDR), .BCAST_EN(BCAST_EN), .PRE_LEN(PRE_LEN),
    .PHY_ID1(16'h0022), .PHY_ID2(16'h1622)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mdc_i(mdc), .mdio_i(mdio_i),
    .mdio_o(mdio_o), .mdio_oe(mdio_oe),
    .wr_strb(wr_strb), .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_strb(rd_strb), .rd_reg(rd_reg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) model_regs[i] = 16'h0000;
    model_regs[0] = 16'h1140;
    model_regs[1] = 16'h796D;
    model_regs[2] = 16'h0022;
    model_regs[3] = 16'h1622;
  endfunction

  // Scoreboard monitor: pops expectations whenever the DUT presents something.
  always @(negedge clk) begin
    if (rd_strb === 1'b1) begin
      check("rd_strb_expected", 32'(exp_rd.size() != 0), 32'd1);
      if (exp_rd.size() != 0) check("rd_reg", 32'(rd_reg), 32'(exp_rd.pop_front()));
    end
    if (wr_strb === 1'b1) begin
      check("wr_strb_expected", 32'(exp_wr.size() != 0), 32'd1);
      if (exp_wr.size() != 0) check("wr_reg_data", 32'({wr_reg, wr_data}), 32'(exp_wr.pop_front()));
    end
    if (mdc === 1'b1 && mdc_prev === 1'b0 && mdio_oe === 1'b1) begin
      cap = {cap[15:0], mdio_o};
      ncap++;
    end
    mdc_prev = mdc;
    if (prev_oe === 1'b1 && mdio_oe === 1'b0) begin
      if (abort_req != abort_ack) begin
        abort_ack++;
      end else begin
        check("rdata_expected", 32'(exp_rdata.size() != 0), 32'd1);
        if (exp_rdata.size() != 0) begin
          check("rdata_bits", 32'(ncap), 32'd17);
          check("rdata", 32'(cap), 32'(exp_rdata.pop_front()));
        end
      end
      cap  = '0;
      ncap = 0;
    end
    prev_oe = mdio_oe;
  end

  task automatic send_bit(input logic b);
    int lo, hi;
    lo = $urandom_range(4, 6);
    hi = $urandom_range(4, 6);
    mdc = 1'b0;
    sta_drv = b;
    repeat (lo) @(negedge clk);
    mdc = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  // Idle 0 bit after each frame; the station only drives once the PHY has let go.
  task automatic tail_bit();
    mdc = 1'b0;
    sta_drv = 1'b1;
    repeat (4) @(negedge clk);
    sta_drv = 1'b0;
    repeat (2) @(negedge clk);
    mdc = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic abort_bit(input logic driving);
    mdc = 1'b0;
    sta_drv = 1'b1;
    repeat (4) @(negedge clk);
    check("oe_before_abort", 32'(mdio_oe), 32'(driving));
    if (driving) abort_req++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_releases_oe", 32'(mdio_oe), 32'd0);
    model_reset();
    mdc = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [15:0] data,
                       input logic [1:0] ta, input int abort_at);
    logic rd_acc, wr_acc;
    rd_acc = (pre >= PRE_LEN) && (op == OP_RD) && (phy == PHY_ADDR) && (phy != 5'd0);
    wr_acc = (pre >= PRE_LEN) && (op == OP_WR) && (ta == 2'b10) &&
             (phy == PHY_ADDR || (BCAST_EN && phy == 5'd0)) && !(ra inside {[5'd1:5'd3]});
    if (rd_acc) begin
      exp_rd.push_back(ra);
      if (abort_at < 0) exp_rdata.push_back({1'b0, model_regs[ra]});
    end
    if (wr_acc) begin
      exp_wr.push_back({ra, data});
      if (ra == 5'd0 && data[15]) model_reset();
      else model_regs[ra] = data;
    end
    repeat (pre) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 1; i >= 0; i--) send_bit(op[i]);
    for (int i = 4; i >= 0; i--) send_bit(phy[i]);
    for (int i = 4; i >= 0; i--) send_bit(ra[i]);
    if (op == OP_RD) begin
      repeat (2) send_bit(1'b1);
      for (int i = 15; i >= 0; i--) begin
        if (i == abort_at) abort_bit(rd_acc);
        else send_bit(1'b1);
      end
    end else begin
      send_bit(ta[1]);
      send_bit(ta[0]);
      for (int i = 15; i >= 0; i--) send_bit(data[i]);
    end
    tail_bit();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op, ta;
    logic [4:0]  phy, ra;
    logic [15:0] data;
    int          pre, sel;

    model_reset();
    repeat (3) @(negedge clk);
    check("rst_mdio_oe", 32'(mdio_oe), 32'd0);
    check("rst_mdio_o", 32'(mdio_o), 32'd1);
    check("rst_wr_strb", 32'(wr_strb), 32'd0);
    check("rst_rd_strb", 32'(rd_strb), 32'd0);
    check("rst_wr_reg", 32'(wr_reg), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_rd_reg", 32'(rd_reg), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    frame(32, OP_RD, 5'd1, 5'd2, 16'h0, 2'b10, -1);
    frame(32, OP_WR, 5'd1, 5'd4, 16'hA5A5, 2'b10, -1);
    frame(32, OP_RD, 5'd1, 5'd4, 16'h0, 2'b10, -1);
    frame(32, OP_RD, 5'd3, 5'd0, 16'h0, 2'b10, -1);
    frame(32, OP_WR, 5'd0, 5'd6, 16'h5555, 2'b10, -1);
    frame(32, OP_RD, 5'd1, 5'd0, 16'h0, 2'b10, -1);
    frame(31, OP_WR, 5'd1, 5'd5, 16'hDEAD, 2'b10, -1);
    frame(32, OP_WR, 5'd1, 5'd5, 16'h1234, 2'b10, -1);
    frame(32, OP_RD, 5'd1, 5'd5, 16'h0, 2'b10, -1);
    frame(32, OP_WR, 5'd1, 5'd4, 16'hFFFF, 2'b10, -1);
    frame(32, OP_WR, 5'd1, 5'd0, 16'h8000, 2'b10, -1);
    frame(32, OP_RD, 5'd1, 5'd0, 16'h0, 2'b10, -1);
    frame(32, OP_RD, 5'd1, 5'd4, 16'h0, 2'b10, -1);
    frame(32, OP_WR, 5'd1, 5'd2, 16'h0000, 2'b10, -1);
    frame(32, OP_RD, 5'd1, 5'd2, 16'h0, 2'b10, -1);
    frame(32, OP_WR, 5'd1, 5'd7, 16'h0F0F, 2'b10, -1);
    frame(32, OP_RD, 5'd1, 5'd3, 16'h0, 2'b10, 8);
    frame(32, OP_RD, 5'd1, 5'd3, 16'h0, 2'b10, -1);
    frame(32, OP_RD, 5'd1, 5'd7, 16'h0, 2'b10, -1);

    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 9);
      op  = (sel < 4) ? OP_RD : (sel < 8) ? OP_WR : 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 5);
      phy = (sel < 3) ? PHY_ADDR : (sel == 3) ? 5'd0 : (sel == 4) ? 5'd3 : 5'($urandom_range(0, 31));
      ra  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      data = 16'($urandom);
      pre = ($urandom_range(0, 7) == 0) ? 31 : 32 + $urandom_range(0, 4);
      ta  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
      frame(pre, op, phy, ra, data, ta, -1);
    end

    repeat (20) @(negedge clk);
    check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    check("rdata_queue_drained", 32'(exp_rdata.size()), 32'd0);
    check("abort_seen", 32'(abort_ack), 32'(abort_req));
    check("final_mdio_oe", 32'(mdio_oe), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
